// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the handshake and command signals between the fetch/decode side and the pc sequencer.
// Ports: run/fetch_ack/br_valid/br_offset flow into the sequencer.
//        br_ready/fetch_req/inc/add/sub/offset/busy/err flow out of it.
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             run;
  logic             fetch_ack;
  logic             br_valid;
  logic [WIDTH-1:0] br_offset;
  logic             br_ready;
  logic             fetch_req;
  logic             inc;
  logic             add;
  logic             sub;
  logic [WIDTH-1:0] offset;
  logic             busy;
  logic             err;

  // The master side drives the controls and consumes the pc commands.
  modport master (
    output run, fetch_ack, br_valid, br_offset,
    input  br_ready, fetch_req, inc, add, sub, offset, busy, err
  );

  // The slave side is the sequencer itself.
  modport slave (
    input  run, fetch_ack, br_valid, br_offset,
    output br_ready, fetch_req, inc, add, sub, offset, busy, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: Moore controller that issues inc/add/sub commands to the pc datapath.
//   It handshakes fetches and holds one pending relative branch as a sign plus a magnitude.
// Ports: clk_i is the rising-edge clock, reset_ni is the async active-low reset, and bus is the slave side of pc_sequencer_if.
// Latency: 2 cycles per instruction at minimum (FETCH with immediate ack, then UPDATE).
//   Branch slot backpressure: br_ready drops while a branch is pending.
module pc_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pending_q, pending_d;
  logic             neg_q, neg_d;      // stored branch is backwards (sub)
  logic [WIDTH-1:0] mag_q, mag_d;      // stored branch magnitude

  // State register plus the branch-slot, counter and error registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      neg_q     <= 1'b0;
      mag_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      neg_q     <= neg_d;
      mag_q     <= mag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.run && !err_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.fetch_ack) begin
          state_d = ST_UPDATE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // The final waiting cycle is the TIMEOUT-th FETCH cycle.
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_UPDATE: begin
        state_d = bus.run ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Branch slot. A capture needs pending=0, so it can never coincide with
  // the UPDATE that consumes a stored branch.
  always_comb begin
    pending_d = pending_q;
    neg_d     = neg_q;
    mag_d     = mag_q;
    if (bus.br_valid && !pending_q) begin
      pending_d = 1'b1;
      neg_d     = bus.br_offset[WIDTH-1];
      // Two's-complement negate. The most-negative value maps to itself,
      // which is still correct modulo 2^WIDTH when it is subtracted.
      mag_d     = bus.br_offset[WIDTH-1] ? (~bus.br_offset + 1'b1) : bus.br_offset;
    end else if (state_q == ST_UPDATE && pending_q) begin
      pending_d = 1'b0;
      mag_d     = '0;
    end
  end

  // Moore outputs
  always_comb begin
    bus.fetch_req = (state_q == ST_FETCH);
    bus.inc       = (state_q == ST_UPDATE) && !pending_q;
    bus.add       = (state_q == ST_UPDATE) &&  pending_q && !neg_q;
    bus.sub       = (state_q == ST_UPDATE) &&  pending_q &&  neg_q;
    bus.offset    = ((state_q == ST_UPDATE) && pending_q) ? mag_q : '0;
    bus.busy      = (state_q != ST_IDLE);
    bus.err       = err_q;
    bus.br_ready  = !pending_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] pc;

  pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  pc_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference pc datapath driven by the sequencer commands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pc <= 16'h0000;
    else if (bus.inc) pc <= pc + 16'h0001;
    else if (bus.add) pc <= pc + bus.offset;
    else if (bus.sub) pc <= pc - bus.offset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Command invariants are checked on every falling edge while out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("onehot_cmd", 32'(bus.inc) + 32'(bus.add) + 32'(bus.sub) <= 1 ? 32'd1 : 32'd0, 32'd1);
      if (!bus.add && !bus.sub) chk("offset_idle", 32'(bus.offset), 32'd0);
    end
  end

  // Expects the DUT to be in FETCH with fetch_ack=1 at the call.
  task automatic do_branch(input logic [15:0] off, input logic e_add, input logic e_sub,
                           input logic [15:0] e_mag, input logic [15:0] e_pc);
    bus.br_valid  = 1'b1;
    bus.br_offset = off;
    step();
    bus.br_valid  = 1'b0;
    chk("br_ready_pend", 32'(bus.br_ready), 32'd0);
    chk("br_inc", 32'(bus.inc), 32'd0);
    chk("br_add", 32'(bus.add), 32'(e_add));
    chk("br_sub", 32'(bus.sub), 32'(e_sub));
    chk("br_offset", 32'(bus.offset), 32'(e_mag));
    step();
    chk("br_pc", 32'(pc), 32'(e_pc));
    chk("br_ready_free", 32'(bus.br_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0; bus.fetch_ack = 1'b0; bus.br_valid = 1'b0; bus.br_offset = '0;
    #2;
    // Reset state
    chk("rst_br_ready", 32'(bus.br_ready), 32'd1);
    chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_inc", 32'(bus.inc), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_offset", 32'(bus.offset), 32'd0);

    step();
    reset_n = 1'b1; bus.run = 1'b1; bus.fetch_ack = 1'b1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    step();
    // Fetch and inc alternate every cycle.
    for (int i = 0; i < 6; i++) begin
      chk("loop_fetch_req", 32'(bus.fetch_req), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("loop_inc", 32'(bus.inc), (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end
    chk("loop_pc3", 32'(pc), 32'h3);
    step(); step(); step(); step();
    chk("loop_pc5", 32'(pc), 32'h5);

    // Branch chain: +0x10, -13, -3, +0x7FFB, then -0x8000
    do_branch(16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0015);
    do_branch(16'hFFF3, 1'b0, 1'b1, 16'h000D, 16'h0008);
    do_branch(16'hFFFD, 1'b0, 1'b1, 16'h0003, 16'h0005);
    do_branch(16'h7FFB, 1'b1, 1'b0, 16'h7FFB, 16'h8000);
    do_branch(16'h8000, 1'b0, 1'b1, 16'h8000, 16'h0000);

    // A second request while one is pending must wait and must not overwrite.
    bus.br_valid = 1'b1; bus.br_offset = 16'h0002;
    step();
    bus.br_offset = 16'h0004;
    chk("dbl_ready0", 32'(bus.br_ready), 32'd0);
    chk("dbl_add1", 32'(bus.add), 32'd1);
    chk("dbl_off1", 32'(bus.offset), 32'h2);
    step();
    chk("dbl_pc1", 32'(pc), 32'h2);
    chk("dbl_ready1", 32'(bus.br_ready), 32'd1);
    step();
    bus.br_valid = 1'b0;
    chk("dbl_add2", 32'(bus.add), 32'd1);
    chk("dbl_off2", 32'(bus.offset), 32'h4);
    step();
    chk("dbl_pc2", 32'(pc), 32'h6);

    // Fetch timeout
    bus.fetch_ack = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_fetch_req", 32'(bus.fetch_req), 32'd1);
      chk("to_err_low", 32'(bus.err), 32'd0);
      step();
    end
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    chk("to_fetch_off", 32'(bus.fetch_req), 32'd0);
    chk("to_pc", 32'(pc), 32'h6);
    bus.fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_stuck_busy", 32'(bus.busy), 32'd0);
      chk("err_sticky", 32'(bus.err), 32'd1);
    end
    bus.br_valid = 1'b1; bus.br_offset = 16'h0001;
    step();
    bus.br_valid = 1'b0;
    chk("err_br_ready", 32'(bus.br_ready), 32'd0);
    chk("err_pc", 32'(pc), 32'h6);

    // Reset clears err; then abort a FETCH with a branch pending.
    #2 reset_n = 1'b0;
    #1 chk("rst2_err", 32'(bus.err), 32'd0);
    step();
    reset_n = 1'b1; bus.fetch_ack = 1'b0;
    step();
    bus.br_valid = 1'b1; bus.br_offset = 16'h0040;
    step();
    bus.br_valid = 1'b0;
    chk("ab_pend", 32'(bus.br_ready), 32'd0);
    chk("ab_fetch", 32'(bus.fetch_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ab_async_fetch", 32'(bus.fetch_req), 32'd0);
    chk("ab_async_ready", 32'(bus.br_ready), 32'd1);
    chk("ab_async_busy", 32'(bus.busy), 32'd0);
    step();
    reset_n = 1'b1; bus.fetch_ack = 1'b1;
    step();
    step();
    chk("ab_inc", 32'(bus.inc), 32'd1);
    chk("ab_add", 32'(bus.add), 32'd0);
    chk("ab_offset", 32'(bus.offset), 32'd0);
    step();
    chk("ab_pc", 32'(pc), 32'h1);

    // Dropping run in FETCH still completes that fetch and its update.
    bus.run = 1'b0;
    step();
    chk("norun_inc", 32'(bus.inc), 32'd1);
    step();
    chk("norun_idle", 32'(bus.busy), 32'd0);
    chk("norun_pc", 32'(pc), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
